// File: rtl/div_unit_if.sv
// Handshake bundle between the execute stage (master) and the multi-cycle divider (slave).
interface div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start_i;
  logic             kill_i;
  logic [1:0]       op_i;
  logic [WIDTH-1:0] dividend_i;
  logic [WIDTH-1:0] divisor_i;
  logic             busy_o;
  logic             valid_o;
  logic [WIDTH-1:0] result_o;

  modport master (
    output start_i, kill_i, op_i, dividend_i, divisor_i,
    input  busy_o, valid_o, result_o
  );

  modport slave (
    input  start_i, kill_i, op_i, dividend_i, divisor_i,
    output busy_o, valid_o, result_o
  );
endinterface

// File: rtl/div_unit.sv
// Radix-2 restoring divider, one quotient bit per cycle, with RISC-V M-extension
// results for divide-by-zero and signed overflow. WIDTH must be at least 4.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic      clk_i,
  input  logic      rst_i,
  div_unit_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ITER, FIX, SPEC} state_e;

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic             rem_sel_q;
  logic             qneg_q;
  logic             rneg_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH-1:0] result_q;
  logic             busy_q;
  logic             valid_q;

  // Operand decode at acceptance
  logic             op_signed;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;
  logic             div_zero;
  logic             ovf;
  logic [WIDTH-1:0] spec_res;

  assign op_signed = ~bus.op_i[0];
  assign a_neg     = op_signed & bus.dividend_i[WIDTH-1];
  assign b_neg     = op_signed & bus.divisor_i[WIDTH-1];
  assign a_abs     = a_neg ? -bus.dividend_i : bus.dividend_i;
  assign b_abs     = b_neg ? -bus.divisor_i  : bus.divisor_i;
  assign div_zero  = (bus.divisor_i == '0);
  assign ovf       = op_signed && (bus.dividend_i == MIN_INT) && (bus.divisor_i == '1);

  // Remainder of a divide-by-zero is the original, un-negated dividend.
  always_comb begin
    spec_res = '0;
    if (div_zero) begin
      spec_res = bus.op_i[1] ? bus.dividend_i : '1;
    end else begin
      spec_res = bus.op_i[1] ? '0 : MIN_INT;
    end
  end

  // One restoring step; the trial difference fits in WIDTH+1 bits since rem < divisor.
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] rem_d;
  logic [WIDTH-1:0] quo_d;

  assign rem_sh = {rem_q, quo_q[WIDTH-1]};
  assign trial  = rem_sh - {1'b0, dvs_q};
  assign rem_d  = trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
  assign quo_d  = {quo_q[WIDTH-2:0], ~trial[WIDTH]};

  logic [WIDTH-1:0] fix_res;
  assign fix_res = rem_sel_q ? (rneg_q ? -rem_q : rem_q)
                             : (qneg_q ? -quo_q : quo_q);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rem_sel_q <= 1'b0;
      qneg_q    <= 1'b0;
      rneg_q    <= 1'b0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      result_q  <= '0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (state_q != IDLE && bus.kill_i) begin
        state_q <= IDLE;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (bus.start_i) begin
              busy_q    <= 1'b1;
              rem_sel_q <= bus.op_i[1];
              qneg_q    <= a_neg ^ b_neg;
              rneg_q    <= a_neg;
              cnt_q     <= '0;
              rem_q     <= '0;
              dvs_q     <= b_abs;
              if (div_zero || ovf) begin
                quo_q   <= spec_res;
                state_q <= SPEC;
              end else begin
                quo_q   <= a_abs;
                state_q <= ITER;
              end
            end
          end
          ITER: begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
              state_q <= FIX;
            end
          end
          FIX: begin
            result_q <= fix_res;
            valid_q  <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= IDLE;
          end
          SPEC: begin
            result_q <= quo_q;
            valid_q  <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.busy_o   = busy_q;
  assign bus.valid_o  = valid_q;
  assign bus.result_o = result_q;
endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: 32-bit and 8-bit instances, handshake timing, kill and reset.
module tb_div_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  div_unit_if #(.WIDTH(32)) if32();
  div_unit_if #(.WIDTH(8))  if8();

  div_unit #(.WIDTH(32)) dut32 (.clk_i(clk), .rst_i(rst), .bus(if32));
  div_unit #(.WIDTH(8))  dut8  (.clk_i(clk), .rst_i(rst), .bus(if8));

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] q32[$];
  logic [31:0] q8[$];
  string       t32[$];
  string       t8[$];
  logic [31:0] last32 = '0;
  logic [31:0] last8  = '0;

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && if32.valid_o) begin
      if (q32.size() == 0) check("unexpected_valid32", 64'(if32.valid_o), 64'd0);
      else check(t32.pop_front(), 64'(if32.result_o), 64'(q32.pop_front()));
    end
  end

  always @(negedge clk) begin
    if (!rst && if8.valid_o) begin
      if (q8.size() == 0) check("unexpected_valid8", 64'(if8.valid_o), 64'd0);
      else check(t8.pop_front(), 64'(if8.result_o), 64'(q8.pop_front()));
    end
  end

  function automatic logic [31:0] model32(logic [1:0] op, logic [31:0] a, logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    sa = a;
    sb = b;
    case (op)
      2'b00: if (b == 0) return 32'hFFFF_FFFF;
             else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
             else return 32'(sa / sb);
      2'b01: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      2'b10: if (b == 0) return a;
             else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
             else return 32'(sa % sb);
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic logic get_valid(bit w8);
    return w8 ? if8.valid_o : if32.valid_o;
  endfunction

  function automatic logic get_busy(bit w8);
    return w8 ? if8.busy_o : if32.busy_o;
  endfunction

  task automatic drive(bit w8, logic [1:0] op, logic [31:0] a, logic [31:0] b, bit st, bit kl);
    if (w8) begin
      if8.start_i = st; if8.kill_i = kl; if8.op_i = op;
      if8.dividend_i = a[7:0]; if8.divisor_i = b[7:0];
    end else begin
      if32.start_i = st; if32.kill_i = kl; if32.op_i = op;
      if32.dividend_i = a; if32.divisor_i = b;
    end
  endtask

  // Drives start now (caller sits mid-cycle with busy low) and returns in the valid cycle.
  task automatic do_op(bit w8, logic [1:0] op, logic [31:0] a, logic [31:0] b,
                       logic [31:0] exp, int lat, string tag, bit kidle, bit poke);
    int e;
    bit got;
    bit pb;
    drive(w8, op, a, b, 1'b1, kidle);
    if (w8) begin q8.push_back(exp); t8.push_back(tag); end
    else begin q32.push_back(exp); t32.push_back(tag); end
    @(posedge clk);
    #1 drive(w8, op, a, b, 1'b0, 1'b0);
    e = 0; got = 0; pb = 0;
    while (!got && e < 200) begin
      @(negedge clk);
      if (e == 0) check({tag, "_busy_e0"}, 64'(get_busy(w8)), 64'd1);
      if (get_valid(w8)) begin
        got = 1;
        check({tag, "_lat"}, 64'(e), 64'(lat));
        check({tag, "_busy_valid"}, 64'(get_busy(w8)), 64'd0);
        check({tag, "_busy_pre"}, 64'(pb), 64'd1);
      end else begin
        pb = get_busy(w8);
        if (poke && e == 5) drive(1'b0, 2'b01, 32'd50, 32'd5, 1'b1, 1'b0);
        if (poke && e == 6) if32.start_i = 1'b0;
        @(posedge clk);
        e++;
      end
    end
    if (!got) check({tag, "_timeout"}, 64'(get_valid(w8)), 64'd1);
    else if (w8) last8 = exp;
    else last32 = exp;
  endtask

  task automatic kill_op(logic [1:0] op, logic [31:0] a, logic [31:0] b, int kat, string tag);
    int nv;
    drive(1'b0, op, a, b, 1'b1, 1'b0);
    @(posedge clk);
    #1 if32.start_i = 1'b0;
    repeat (kat) @(posedge clk);
    #1 if32.kill_i = 1'b1;
    @(posedge clk);
    #1 if32.kill_i = 1'b0;
    @(negedge clk);
    check({tag, "_busy"}, 64'(if32.busy_o), 64'd0);
    check({tag, "_valid"}, 64'(if32.valid_o), 64'd0);
    check({tag, "_result"}, 64'(if32.result_o), 64'(last32));
    nv = 0;
    repeat (40) begin
      @(negedge clk);
      if (if32.valid_o) nv++;
    end
    check({tag, "_novalid"}, 64'(nv), 64'd0);
  endtask

  initial begin
    int nv;
    drive(1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 1'b0);
    drive(1'b1, 2'b00, 32'd0, 32'd0, 1'b0, 1'b0);
    @(negedge clk);
    check("rst_busy32", 64'(if32.busy_o), 64'd0);
    check("rst_valid32", 64'(if32.valid_o), 64'd0);
    check("rst_result32", 64'(if32.result_o), 64'd0);
    check("rst_busy8", 64'(if8.busy_o), 64'd0);
    check("rst_valid8", 64'(if8.valid_o), 64'd0);
    check("rst_result8", 64'(if8.result_o), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed 32-bit cases; each call starts in the previous valid cycle (back-to-back).
    do_op(0, 2'b01, 32'd5463, 32'd31, 32'd176, 33, "divu_5463_31_poke", 0, 1);
    do_op(0, 2'b11, 32'd5463, 32'd31, 32'd7, 33, "remu_5463_31", 0, 0);
    do_op(0, 2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, "div_m7_2", 0, 0);
    do_op(0, 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, "rem_m7_2", 0, 0);
    do_op(0, 2'b00, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33, "div_7_m2", 0, 0);
    do_op(0, 2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 33, "rem_7_m2", 0, 0);
    do_op(0, 2'b01, 32'd100, 32'd0, 32'hFFFF_FFFF, 1, "divu_by0", 0, 0);
    do_op(0, 2'b11, 32'd100, 32'd0, 32'd100, 1, "remu_by0", 0, 0);
    do_op(0, 2'b00, 32'd100, 32'd0, 32'hFFFF_FFFF, 1, "div_by0", 0, 0);
    do_op(0, 2'b10, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 1, "rem_m5_by0", 0, 0);
    do_op(0, 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "div_ovf", 0, 0);
    do_op(0, 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, "rem_ovf", 0, 0);
    do_op(0, 2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 33, "divu_min_all1", 0, 0);
    do_op(0, 2'b01, 32'd50, 32'd5, 32'd10, 33, "divu_50_5_b2b", 0, 0);
    do_op(0, 2'b01, 32'd50, 32'd5, 32'd10, 33, "divu_50_5_killidle", 1, 0);

    kill_op(2'b01, 32'd1000, 32'd3, 10, "kill_iter10");
    do_op(0, 2'b01, 32'd1000, 32'd3, 32'd333, 33, "divu_1000_3", 0, 0);
    kill_op(2'b01, 32'd1000, 32'd3, 32, "kill_fix");
    kill_op(2'b00, 32'd1000, 32'd0, 0, "kill_spec");

    for (int i = 0; i < 12; i++) begin
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      int          lat;
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      case ($urandom_range(0, 5))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 15));
        2:       b = 32'hFFFF_FFFF;
        default: b = $urandom;
      endcase
      if (i == 0) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; op = 2'b00; end
      lat = (b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) ? 1 : 33;
      do_op(0, op, a, b, model32(op, a, b), lat, $sformatf("rand%0d_op%0d", i, op), 0, 0);
    end

    // 8-bit instance
    do_op(1, 2'b01, 32'd200, 32'd7, 32'd28, 9, "w8_divu_200_7", 0, 0);
    do_op(1, 2'b11, 32'd200, 32'd7, 32'd4, 9, "w8_remu_200_7", 0, 0);
    do_op(1, 2'b00, 32'h80, 32'hFF, 32'h80, 1, "w8_div_ovf", 0, 0);

    // Asynchronous reset in the middle of 1000 / 3
    drive(1'b0, 2'b01, 32'd1000, 32'd3, 1'b1, 1'b0);
    @(posedge clk);
    #1 if32.start_i = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_busy", 64'(if32.busy_o), 64'd0);
    check("rst_mid_valid", 64'(if32.valid_o), 64'd0);
    check("rst_mid_result", 64'(if32.result_o), 64'd0);
    check("rst_mid_result8", 64'(if8.result_o), 64'd0);
    #3 rst = 1'b0;
    nv = 0;
    repeat (40) begin
      @(negedge clk);
      if (if32.valid_o) nv++;
    end
    check("rst_mid_novalid", 64'(nv), 64'd0);
    check("rst_mid_result_hold", 64'(if32.result_o), 64'd0);
    check("scoreboard_empty32", 64'(q32.size()), 64'd0);
    check("scoreboard_empty8", 64'(q8.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
